// File: rtl/dec_to_bin.sv
// Sequential BCD-to-binary converter.
// It consumes one BCD digit per clock, most significant digit first, and
// accumulates acc = acc*10 + digit. Invalid digits (> 9) and results wider
// than WIDTH bits are reported with flags that stay valid until the next done.
module dec_to_bin #(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_data,
  output logic [WIDTH-1:0]        bin_data,
  output logic                    done,
  output logic                    busy,
  output logic                    err_invalid,
  output logic                    err_overflow
);

  localparam int AW = WIDTH + 4;
  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  localparam logic [AW-1:0] MAX_VAL  = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_q;
  logic [SW-1:0]   shreg_q,  shreg_d;
  logic [AW-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            inv_q,    inv_d;
  logic            ovf_q,    ovf_d;
  logic [3:0]      digit;
  logic [WIDTH+1:0] result_d;

  logic [WIDTH-1:0] bin_q;
  logic             done_q;
  logic             busy_q;
  logic             err_inv_q;
  logic             err_ovf_q;

  // Final output selection: an invalid digit wins over overflow, and overflow
  // saturates the result. Returns {bin, err_invalid, err_overflow}.
  function automatic logic [WIDTH+1:0] sat_result(input logic [AW-1:0] acc,
                                                  input logic          inv,
                                                  input logic          ovf);
    logic [WIDTH+1:0] r;
    if (inv) begin
      r = {{WIDTH{1'b0}}, 1'b1, 1'b0};
    end else if (ovf) begin
      r = {{WIDTH{1'b1}}, 1'b0, 1'b1};
    end else begin
      r = {acc[WIDTH-1:0], 1'b0, 1'b0};
    end
    return r;
  endfunction

  // One conversion step: multiply-accumulate the top nibble and update sticky flags.
  // The accumulator only grows past WIDTH bits after overflow is already latched,
  // and acc*10+9 of any in-range value still fits in WIDTH+4 bits.
  always_comb begin
    digit    = shreg_q[SW-1 -: 4];
    acc_d    = (acc_q << 3) + (acc_q << 1) + AW'(digit);
    inv_d    = inv_q | (digit > 4'd9);
    ovf_d    = ovf_q | (acc_d > MAX_VAL);
    shreg_d  = shreg_q << 4;
    cnt_d    = cnt_q + CW'(1);
    result_d = sat_result(acc_d, inv_d, ovf_d);
  end

  // Control FSM with registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bin_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_inv_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q <= bcd_data;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          shreg_q <= shreg_d;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          inv_q   <= inv_d;
          ovf_q   <= ovf_d;
          if (cnt_q == LAST_CNT) begin
            bin_q     <= result_d[WIDTH+1:2];
            err_inv_q <= result_d[1];
            err_ovf_q <= result_d[0];
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bin_data     = bin_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign err_invalid  = err_inv_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// Directed bench for dec_to_bin: a vector table of BCD inputs with
// hand-computed results, plus sequences for reset abort and handshake timing.
module tb_dec_to_bin;

  localparam int WIDTH = 16;
  localparam int ND    = 5;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            start;
  logic [4*ND-1:0] bcd_data;
  logic [WIDTH-1:0] bin_data;
  logic            done, busy, err_invalid, err_overflow;

  int total = 0;
  int bad   = 0;

  dec_to_bin #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start        (start),
    .bcd_data     (bcd_data),
    .bin_data     (bin_data),
    .done         (done),
    .busy         (busy),
    .err_invalid  (err_invalid),
    .err_overflow (err_overflow)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        inv;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Independent decimal-to-BCD model used for the round-trip vectors.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [19:0] b, input logic [15:0] r,
                              input logic i, input logic o);
    vec_t v;
    v.bcd = b; v.bin = r; v.inv = i; v.ovf = o;
    return v;
  endfunction

  // One conversion: start sampled at edge 0, input scrambled afterwards,
  // done latency and pulse width measured with a bounded wait.
  task automatic do_conv(input logic [19:0] bcd, output int lat, output int width);
    @(negedge clk_i);
    start = 1'b1;
    bcd_data = bcd;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    bcd_data = 20'hFFFFF;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    width = 0;
    if (lat > 0) begin
      width = 1;
      @(posedge clk_i);
      #1;
      if (done) width = 2;
    end
  endtask

  initial begin
    int lat, width, ndone, first;
    int rt_vals[10] = '{0, 1, 9, 10, 99, 100, 4095, 9999, 10000, 65535};

    vecs.push_back(mk(20'h00037, 16'd37,    1'b0, 1'b0));
    vecs.push_back(mk(20'h00255, 16'd255,   1'b0, 1'b0));
    vecs.push_back(mk(20'h01023, 16'd1023,  1'b0, 1'b0));
    vecs.push_back(mk(20'h09999, 16'd9999,  1'b0, 1'b0));
    vecs.push_back(mk(20'h65535, 16'd65535, 1'b0, 1'b0));
    vecs.push_back(mk(20'h65536, 16'hFFFF,  1'b0, 1'b1));
    vecs.push_back(mk(20'h99999, 16'hFFFF,  1'b0, 1'b1));
    vecs.push_back(mk(20'h00000, 16'd0,     1'b0, 1'b0));
    vecs.push_back(mk(20'h0A123, 16'd0,     1'b1, 1'b0));
    vecs.push_back(mk(20'hF9999, 16'd0,     1'b1, 1'b0));
    foreach (rt_vals[k]) vecs.push_back(mk(to_bcd(rt_vals[k]), 16'(rt_vals[k]), 1'b0, 1'b0));

    reset_i = 1'b1;
    start = 1'b0;
    bcd_data = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset bin_data", 32'(bin_data), 32'd0);
    chk("reset done",     32'(done),     32'd0);
    chk("reset busy",     32'(busy),     32'd0);
    chk("reset flags",    32'({err_invalid, err_overflow}), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Table-driven conversions.
    foreach (vecs[n]) begin
      do_conv(vecs[n].bcd, lat, width);
      chk($sformatf("v%0d latency", n), 32'(lat), 32'd5);
      chk($sformatf("v%0d done width", n), 32'(width), 32'd1);
      chk($sformatf("v%0d bin 0x%05h", n, vecs[n].bcd), 32'(bin_data), 32'(vecs[n].bin));
      chk($sformatf("v%0d err_invalid", n), 32'(err_invalid), 32'(vecs[n].inv));
      chk($sformatf("v%0d err_overflow", n), 32'(err_overflow), 32'(vecs[n].ovf));
      chk($sformatf("v%0d busy after", n), 32'(busy), 32'd0);
    end

    // Reset in the middle of a conversion aborts it with no done pulse.
    do_conv(20'h00037, lat, width);
    @(negedge clk_i);
    start = 1'b1;
    bcd_data = 20'h12345;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    chk("midreset busy before", 32'(busy), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("midreset async busy", 32'(busy), 32'd0);
    chk("midreset async bin", 32'(bin_data), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (done) ndone++;
    end
    chk("midreset done count", 32'(ndone), 32'd0);
    chk("midreset outputs", 32'({bin_data, done, busy, err_invalid, err_overflow}), 32'd0);

    // Start pulses during CONV (edge 3) and DONE (edge 6) are ignored.
    @(negedge clk_i);
    start = 1'b1;
    bcd_data = 20'h00100;
    @(posedge clk_i);
    ndone = 0;
    first = -1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_i);
      start = (i == 3 || i == 6);
      bcd_data = 20'h00200;
      @(posedge clk_i);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (i == 6) chk("hs busy after DONE start", 32'(busy), 32'd0);
    end
    start = 1'b0;
    chk("hs done count", 32'(ndone), 32'd1);
    chk("hs done edge", 32'(first), 32'd5);
    chk("hs bin", 32'(bin_data), 32'd100);

    // Back-to-back: overflow conversion then start at edge 7 clears flags.
    @(negedge clk_i);
    start = 1'b1;
    bcd_data = 20'h65536;
    @(posedge clk_i);
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      start = (i == 7);
      bcd_data = (i == 7) ? 20'h00042 : 20'h99999;
      @(posedge clk_i);
      #1;
      if (i == 5) chk("b2b first ovf", 32'(err_overflow), 32'd1);
      if (i == 7) chk("b2b busy at start", 32'(busy), 32'd1);
      if (done && i > 7 && first < 0) first = i;
    end
    start = 1'b0;
    chk("b2b second done edge", 32'(first), 32'd12);
    chk("b2b bin", 32'(bin_data), 32'd42);
    chk("b2b flags cleared", 32'({err_invalid, err_overflow}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
